// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: next-PC source
// encodings, the redirect-holding state encoding and default vectors.
package pc_pkg;

  // Next-PC source selection presented by the decode stage
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  // Default reset and exception entry vectors (zero-extended by the user)
  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR_DEFAULT   = 32'h0000_0180;

  // RUN: no redirect held; PEND_*: a redirect arrived during a stall
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PEND_EXC  = 2'd1,
    PEND_ERET = 2'd2
  } pc_state_e;

  // Instruction addresses must sit on a 4-byte boundary
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pc_reg_en.sv
// WIDTH-bit register with synchronous active-high reset to a
// configurable value and a load enable. Used for both pc and epc.
module pc_reg_en #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over the enable; otherwise load only when enabled
  always_ff @(posedge clk) begin
    if (clrn) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter. Picks the next PC from sequential,
// branch, jump, register-jump, exception and exception-return sources,
// keeps the EPC, and remembers an exc/eret that arrives while the
// pipeline is stalled so it is applied as soon as the stall releases.
import pc_pkg::*;

module pc_sequencer #(
  parameter int          WIDTH        = 32,
  parameter int          INST_BYTES   = 4,
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEFAULT,
  parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR_DEFAULT
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wir,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] br_target,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic             pending
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] PC_INC   = WIDTH'(INST_BYTES);

  pc_state_e        state;
  pc_state_e        state_next;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] sel_target;
  logic [WIDTH-1:0] pc_next;
  logic             held_exc;
  logic             held_eret;
  logic             jr_misaligned;
  logic             take_exc;
  logic             take_eret;
  logic             misalign_hit;
  logic             epc_en;

  // Sequential address wraps naturally; the carry out is dropped
  assign pc_plus = pc + PC_INC;

  // J-type target keeps the region bits of the delay-slot address
  assign jump_target = {pc_plus[WIDTH-1:28], j_index, 2'b00};

  // Ordinary next-PC selection requested by decode
  always_comb begin
    sel_target = pc_plus;
    case (pcsrc)
      PC_SEQ:  sel_target = pc_plus;
      PC_BR:   sel_target = br_target;
      PC_J:    sel_target = jump_target;
      PC_JR:   sel_target = reg_target;
      default: sel_target = pc_plus;
    endcase
  end

  // Resolve the effective request: exc beats eret beats pcsrc. A
  // misaligned register jump only matters when it is the winning
  // source, and is then turned into an exception entry.
  always_comb begin
    held_exc      = (state == PEND_EXC);
    held_eret     = (state == PEND_ERET);
    jr_misaligned = (pcsrc == PC_JR) && !is_word_aligned(reg_target[1:0]);
    take_exc      = exc || held_exc ||
                    (!eret && !held_eret && jr_misaligned);
    take_eret     = !take_exc && (eret || held_eret);
    misalign_hit  = wir && jr_misaligned && !exc && !held_exc &&
                    !eret && !held_eret;
    epc_en        = wir && take_exc;
  end

  // Next PC value, loaded only when the stage is not stalled
  always_comb begin
    pc_next = sel_target;
    if (take_exc) begin
      pc_next = EXC_PC;
    end else if (take_eret) begin
      pc_next = epc;
    end
  end

  // Redirect-holding FSM: any release applies the held request and
  // returns to RUN; during a stall an exc always supersedes an eret.
  always_comb begin
    state_next = state;
    if (wir) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (exc) begin
            state_next = PEND_EXC;
          end else if (eret) begin
            state_next = PEND_ERET;
          end
        end
        PEND_ERET: begin
          if (exc) begin
            state_next = PEND_EXC;
          end
        end
        PEND_EXC: begin
          state_next = PEND_EXC;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // State register; reset discards any held redirect
  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Misalign flag lives for exactly the cycle after the bad jump
  always_ff @(posedge clk) begin
    if (clrn) begin
      misalign <= 1'b0;
    end else begin
      misalign <= misalign_hit;
    end
  end

  assign pending = (state != RUN);

  pc_reg_en #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .clrn (clrn),
    .en   (wir),
    .d    (pc_next),
    .q    (pc)
  );

  pc_reg_en #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) u_epc_reg (
    .clk  (clk),
    .clrn (clrn),
    .en   (epc_en),
    .d    (pc),
    .q    (epc)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the PC
// stage kept here in the bench.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC   = 32'h0000_0180;
  localparam int HELD_NONE = 0;
  localparam int HELD_EXC  = 1;
  localparam int HELD_ERET = 2;

  logic        clk;
  logic        clrn;
  logic        wir;
  logic [1:0]  pcsrc;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] reg_target;
  logic        exc;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [31:0] epc;
  logic        misalign;
  logic        pending;

  int total;
  int bad;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_mis;
  int          m_held;

  pc_sequencer #(
    .WIDTH        (32),
    .INST_BYTES   (4),
    .RESET_VECTOR (RESET_PC),
    .EXC_VECTOR   (EXC_PC)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .wir        (wir),
    .pcsrc      (pcsrc),
    .br_target  (br_target),
    .j_index    (j_index),
    .reg_target (reg_target),
    .exc        (exc),
    .eret       (eret),
    .pc         (pc),
    .pc_plus    (pc_plus),
    .epc        (epc),
    .misalign   (misalign),
    .pending    (pending)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's worth of inputs
  task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] src,
                               input logic [31:0] br, input logic [25:0] ji,
                               input logic [31:0] rt, input logic ex, input logic er);
    clrn       = rst;
    wir        = we;
    pcsrc      = src;
    br_target  = br;
    j_index    = ji;
    reg_target = rt;
    exc        = ex;
    eret       = er;
  endtask

  // Advance the model by one clock using the architectural rules, then
  // let the DUT take the same edge and settle
  task automatic tick();
    bit          go_exc;
    bit          go_eret;
    logic [31:0] tgt;
    if (clrn) begin
      m_pc   = RESET_PC;
      m_epc  = 32'h0;
      m_mis  = 1'b0;
      m_held = HELD_NONE;
    end else if (wir) begin
      go_exc  = exc || (m_held == HELD_EXC);
      go_eret = !go_exc && (eret || (m_held == HELD_ERET));
      m_mis   = 1'b0;
      tgt     = m_pc + 32'd4;
      if (!go_exc && !go_eret) begin
        case (pcsrc)
          2'd0: tgt = m_pc + 32'd4;
          2'd1: tgt = br_target;
          2'd2: tgt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(j_index) * 32'd4);
          default: begin
            if (reg_target % 4 != 0) begin
              go_exc = 1'b1;
              m_mis  = 1'b1;
            end else begin
              tgt = reg_target;
            end
          end
        endcase
      end
      if (go_exc) begin
        m_epc = m_pc;
        m_pc  = EXC_PC;
      end else if (go_eret) begin
        m_pc = m_epc;
      end else begin
        m_pc = tgt;
      end
      m_held = HELD_NONE;
    end else begin
      m_mis = 1'b0;
      if (exc) begin
        m_held = HELD_EXC;
      end else if (eret && m_held == HELD_NONE) begin
        m_held = HELD_ERET;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset state of every output
  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (pc !== RESET_PC) begin
      bad++;
      $display("[TB] FAIL reset_pc: got %h want %h", pc, RESET_PC);
    end
    total++;
    if (epc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_epc: got %h want 0", epc);
    end
    total++;
    if (misalign !== 1'b0 || pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got mis=%b pend=%b want 0 0", misalign, pending);
    end
  endtask

  // Plain sequential fetch from the reset vector
  task automatic test_sequential();
    logic [31:0] want [3];
    want = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      tick();
      total++;
      if (pc !== want[i] || pc !== m_pc) begin
        bad++;
        $display("[TB] FAIL seq_pc[%0d]: got %h want %h", i, pc, want[i]);
      end
      total++;
      if (pc_plus !== want[i] + 32'd4) begin
        bad++;
        $display("[TB] FAIL seq_pc_plus[%0d]: got %h want %h", i, pc_plus, want[i] + 32'd4);
      end
    end
  endtask

  // J-type target, then a misaligned register jump raising an exception
  task automatic test_jump();
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h1000_0010, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== 32'h1000_0010) begin
      bad++;
      $display("[TB] FAIL jr_aligned: got %h want 10000010", pc);
    end
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h0, 26'h000_0040, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== 32'h1000_0100) begin
      bad++;
      $display("[TB] FAIL j_target: got %h want 10000100", pc);
    end
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h0000_2002, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== EXC_PC || epc !== 32'h1000_0100 || misalign !== 1'b1) begin
      bad++;
      $display("[TB] FAIL jr_misalign: got pc=%h epc=%h mis=%b want 180 10000100 1",
               pc, epc, misalign);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (misalign !== 1'b0 || pc !== 32'h184) begin
      bad++;
      $display("[TB] FAIL misalign_clear: got pc=%h mis=%b want 184 0", pc, misalign);
    end
  endtask

  // Exception arriving during a stall is held and applied on release
  task automatic test_stall_exc();
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h0000_0400, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd1, 32'h0000_9990, 26'h0, 32'h0, (i == 0), 1'b0);
      tick();
      total++;
      if (pc !== 32'h400 || pending !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: got pc=%h pend=%b want 400 1", i, pc, pending);
      end
    end
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h0000_9990, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== EXC_PC || epc !== 32'h400 || pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_release: got pc=%h epc=%h pend=%b want 180 400 0",
               pc, epc, pending);
    end
  endtask

  // eret held in a stall is superseded by a later exc; then eret restores
  task automatic test_eret_then_exc();
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h0000_0800, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    tick();
    total++;
    if (pending !== 1'b1 || pc !== 32'h800) begin
      bad++;
      $display("[TB] FAIL eret_exc_hold: got pc=%h pend=%b want 800 1", pc, pending);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== EXC_PC || epc !== 32'h800 || pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL eret_exc_release: got pc=%h epc=%h pend=%b want 180 800 0",
               pc, epc, pending);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1);
    tick();
    total++;
    if (pc !== 32'h800 || epc !== 32'h800) begin
      bad++;
      $display("[TB] FAIL eret_restore: got pc=%h epc=%h want 800 800", pc, epc);
    end
  endtask

  // exc held high across cycles is taken every cycle
  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b1);
      tick();
    end
    total++;
    if (pc !== EXC_PC || epc !== EXC_PC) begin
      bad++;
      $display("[TB] FAIL exc_repeat: got pc=%h epc=%h want 180 180", pc, epc);
    end
  endtask

  // Address wrap at the top of the space, then reset while a redirect is held
  task automatic test_wrap_and_reset();
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    total++;
    if (pc_plus !== 32'h0) begin
      bad++;
      $display("[TB] FAIL wrap_pc_plus: got %h want 0", pc_plus);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL wrap_pc: got %h want 0", pc);
    end
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h0000_0040, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== RESET_PC || pending !== 1'b0 || epc !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_pending: got pc=%h pend=%b epc=%h want 0 0 0", pc, pending, epc);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++;
    if (pc !== 32'h4) begin
      bad++;
      $display("[TB] FAIL reset_discard: got pc=%h want 4", pc);
    end
  endtask

  // Random traffic against the model, every output checked each cycle
  task automatic test_random();
    logic [31:0] rt;
    for (int i = 0; i < 400; i++) begin
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), {$urandom} & 32'hFFFF_FFFC,
                    26'($urandom), rt, ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0));
      tick();
      total++;
      if (pc !== m_pc || pc_plus !== m_pc + 32'd4 || epc !== m_epc ||
          misalign !== m_mis || pending !== (m_held != HELD_NONE)) begin
        bad++;
        $display("[TB] FAIL random[%0d]: got pc=%h pp=%h epc=%h mis=%b pend=%b want %h %h %h %b %b",
                 i, pc, pc_plus, epc, misalign, pending, m_pc, m_pc + 32'd4, m_epc,
                 m_mis, (m_held != HELD_NONE));
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_pc   = 32'h0;
    m_epc  = 32'h0;
    m_mis  = 1'b0;
    m_held = HELD_NONE;
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_sequential();
    test_jump();
    test_stall_exc();
    test_eret_then_exc();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter stage for the pipelined MIPS core. Holds the fetch PC, selects the next PC from sequential, branch, jump, register-jump, exception and exception-return sources, and honours the pipeline stall enable. Keeps an EPC register and latches redirect requests that arrive during a stall so none is lost. Sits at the front of IF, feeding the instruction memory address and the IF/ID PC+4 path.

## Interface
- WIDTH, 32: address width; legal range 32..64.
- INST_BYTES, 4: sequential increment.
- RESET_VECTOR, 32'h0000_0000: PC value after reset, zero-extended to WIDTH.
- EXC_VECTOR, 32'h0000_0180: exception entry address, zero-extended to WIDTH.

- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  synchronous, active-high reset.
- wir  in  1  PC write enable; 0 = stall (hold PC).
- pcsrc  in  2  00 seq, 01 branch, 10 jump, 11 register.
- br_target  in  WIDTH  branch target from ID.
- j_index  in  26  jump instruction index field.
- reg_target  in  WIDTH  jr/jalr target.
- exc  in  1  exception redirect request, one-cycle pulse.
- eret  in  1  exception-return request, one-cycle pulse.
- pc  out  WIDTH  current fetch address.
- pc_plus  out  WIDTH  pc + INST_BYTES, combinational.
- epc  out  WIDTH  saved exception PC.
- misalign  out  1  registered; set for one cycle after a misaligned register jump.
- pending  out  1  a stalled redirect is held.

## Operation
- Jump target: {pc_plus[WIDTH-1:28], j_index, 2'b00}.
- pc_plus wraps modulo 2^WIDTH; 0xFFFF_FFFC + 4 = 0x0000_0000 at WIDTH=32. Carry is dropped.
- Effective request each cycle, highest priority first:
  1. exc input, or a pending exc.
  2. eret input, or a pending eret.
  3. pcsrc selection.
- Misaligned register jump: pcsrc=11 with reg_target[1:0] != 0 and wir=1 is treated as an internal exc. It sets misalign for one cycle.
- exc applied: pc <= EXC_VECTOR; epc <= pc.
- eret applied: pc <= epc; epc unchanged.
- Normal case: pc <= selected target.
- State machine states: RUN, PEND_EXC, PEND_ERET.
  - RUN with wir=0 and exc -> PEND_EXC.
  - RUN with wir=0, eret and no exc -> PEND_ERET.
  - PEND_ERET with exc (any wir) -> PEND_EXC if wir=0; if wir=1, apply exc and go to RUN.
  - PEND_* with wir=1 -> apply the held request, go to RUN. Current pcsrc is ignored that cycle.
  - PEND_EXC with eret -> eret is dropped; the exc stays held.
- pending = (state != RUN).
- With wir=0, pc and epc hold and misalign clears, whatever the state.

## Timing
- Reset (clrn=1 at an edge): pc=RESET_VECTOR, epc=0, misalign=0, state=RUN, pending=0.
- Reset overrides every request, including one held mid-stall; that request is discarded.
- PC update latency: 1 cycle from a selection presented with wir=1.
- pc_plus is combinational from pc; pc, epc, misalign and pending are registered.
- exc and eret are sampled only at the edge; a pulse held for several cycles is applied once per cycle it is high.
- exc and eret together: exc wins and eret is dropped.

## Structure
- Shared package pc_pkg holds:
  - pcsrc encodings PC_SEQ, PC_BR, PC_J, PC_JR.
  - State enum RUN/PEND_EXC/PEND_ERET.
  - Default vector constants.
- One sub-module is natural: pc_reg_en, a WIDTH-parametrised register with synchronous active-high reset, reset value and enable. It is used for pc and epc.
- Next-PC mux, priority logic and the FSM live in pc_sequencer.

## Test plan
- Reset, then 3 cycles wir=1, pcsrc=00 -> pc 0x0, 0x4, 0x8, 0xC.
- pc=0x1000_0010, pcsrc=10, j_index=0x0000040 -> pc=0x1000_0100. pcsrc=11, reg_target=0x2002 -> pc=0x180, epc=0x1000_0100, misalign=1 for one cycle.
- pc=0x400, wir=0, exc pulse -> pending=1, pc holds 0x400 for 3 stall cycles. First cycle with wir=1 -> pc=0x180, epc=0x400, pending=0.
- Stall with eret, then exc during the same stall -> on release pc=0x180; the eret is dropped.
- pc=0xFFFF_FFFC, pcsrc=00, wir=1 -> pc=0x0. Then clrn=1 while in PEND_EXC -> pc=RESET_VECTOR, pending=0, epc=0.
